// File: rtl/loproc_irq_ctrl_pkg.sv
// loproc_irq_ctrl_pkg: shared widths, FSM encodings, vector defaults and the vector address helper
package loproc_irq_ctrl_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int IRQ_ID_WIDTH = 4;
  localparam logic [31:0] DEF_VEC_BASE = 32'h0000_0010;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0004;
  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_ARMED   = 2'd1,
    IRQ_ST_SERVICE = 2'd2
  } irq_state_e;
  function automatic logic [INSTRUCTION_WIDTH-1:0] vec_addr(
    input logic [31:0] base,
    input logic [31:0] stride,
    input logic [IRQ_ID_WIDTH-1:0] id
  );
    logic [31:0] a;
    a = base + 32'(id) * stride;
    return a[INSTRUCTION_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/loproc_irq_ctrl_if.sv
// loproc_irq_ctrl_if: request, mask/enable and PC-side signals of the interrupt controller
// master drives requests, mask, gie and PC strobes; slave (the controller) returns vector,
// return address, service status, taken id and one-hot acknowledge.
interface loproc_irq_ctrl_if
  import loproc_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_req;
  logic mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic gie_set;
  logic gie_clr;
  logic pc_load;
  logic [INSTRUCTION_WIDTH-1:0] pc_addr;
  logic reti;
  logic interrupt;
  logic [INSTRUCTION_WIDTH-1:0] interrupt_addr;
  logic [INSTRUCTION_WIDTH-1:0] ret_addr;
  logic in_service;
  logic [IRQ_ID_WIDTH-1:0] irq_id;
  logic [NUM_IRQ-1:0] irq_ack;
  modport master (
    output irq_req, mask_we, mask_wdata, gie_set, gie_clr, pc_load, pc_addr, reti,
    input  interrupt, interrupt_addr, ret_addr, in_service, irq_id, irq_ack
  );
  modport slave (
    input  irq_req, mask_we, mask_wdata, gie_set, gie_clr, pc_load, pc_addr, reti,
    output interrupt, interrupt_addr, ret_addr, in_service, irq_id, irq_ack
  );
endinterface

// File: rtl/loproc_irq_prio_enc.sv
// loproc_irq_prio_enc: lowest-index-wins priority encoder; req in, valid and id out
module loproc_irq_prio_enc
  import loproc_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic valid,
  output logic [IRQ_ID_WIDTH-1:0] id
);
  always_comb begin
    valid = |req;
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) id = IRQ_ID_WIDTH'(i);
  end
endmodule

// File: rtl/loproc_irq_ctrl.sv
// loproc_irq_ctrl: edge-latched, masked, prioritised interrupt sequencer for loproc_pc
// clk/rst: clock and async active-high reset; bus: slave side of loproc_irq_ctrl_if.
module loproc_irq_ctrl
  import loproc_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter logic [31:0] VEC_BASE = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input logic clk,
  input logic rst,
  loproc_irq_ctrl_if.slave bus
);
  irq_state_e state_q, state_d;
  logic [NUM_IRQ-1:0] req_q, pending_q, pending_d, mask_q, mask_d, ack_q, ack_d, eligible;
  logic gie_q, gie_d, int_q, int_d, svc_q, svc_d;
  logic [INSTRUCTION_WIDTH-1:0] addr_q, addr_d, ret_q, ret_d;
  logic [IRQ_ID_WIDTH-1:0] id_q, id_d, enc_id;
  logic enc_valid, accept, take;
  assign eligible = pending_q & ~mask_q;
  loproc_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (.req(eligible), .valid(enc_valid), .id(enc_id));
  always_comb begin
    accept = state_q == IRQ_ST_ARMED && bus.pc_load;
    take = gie_q && enc_valid;
    ack_d = accept ? NUM_IRQ'(1) << id_q : '0;
    // a fresh edge in the ack cycle re-raises the line
    pending_d = (pending_q & ~ack_d) | (bus.irq_req & ~req_q);
    mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
    // the vector shown with interrupt=1 is already committed to the PC, so pc_load wins
    state_d = accept ? IRQ_ST_SERVICE
            : state_q == IRQ_ST_SERVICE ? (bus.reti ? IRQ_ST_IDLE : IRQ_ST_SERVICE)
            : take ? IRQ_ST_ARMED : IRQ_ST_IDLE;
    id_d = state_d == IRQ_ST_ARMED ? enc_id : id_q;
    addr_d = state_d == IRQ_ST_ARMED ? vec_addr(VEC_BASE, VEC_STRIDE, enc_id) : addr_q;
    // gie writes are frozen in service; reti restores gie unless cleared in the same cycle
    gie_d = accept ? 1'b0
          : state_q == IRQ_ST_SERVICE ? (bus.reti ? ~bus.gie_clr : gie_q)
          : bus.gie_clr ? 1'b0 : bus.gie_set ? 1'b1 : gie_q;
    int_d = state_d == IRQ_ST_ARMED;
    svc_d = state_d == IRQ_ST_SERVICE;
    ret_d = accept ? bus.pc_addr : ret_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IRQ_ST_IDLE;
      req_q <= '0;
      pending_q <= '0;
      mask_q <= '1;
      ack_q <= '0;
      gie_q <= 1'b0;
      int_q <= 1'b0;
      svc_q <= 1'b0;
      addr_q <= vec_addr(VEC_BASE, VEC_STRIDE, '0);
      ret_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= bus.irq_req;
      pending_q <= pending_d;
      mask_q <= mask_d;
      ack_q <= ack_d;
      gie_q <= gie_d;
      int_q <= int_d;
      svc_q <= svc_d;
      addr_q <= addr_d;
      ret_q <= ret_d;
      id_q <= id_d;
    end
  assign bus.interrupt = int_q;
  assign bus.interrupt_addr = addr_q;
  assign bus.ret_addr = ret_q;
  assign bus.in_service = svc_q;
  assign bus.irq_id = id_q;
  assign bus.irq_ack = ack_q;
endmodule

// File: tb/tb_loproc_irq_ctrl.sv
// tb_loproc_irq_ctrl: directed self-checking bench for loproc_irq_ctrl
module tb_loproc_irq_ctrl;
  logic clk, rst;
  int tests, fails;
  loproc_irq_ctrl_if #(.NUM_IRQ(4)) bus ();
  loproc_irq_ctrl #(.NUM_IRQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_load(input logic [31:0] a);
    bus.pc_addr = a;
    bus.pc_load = 1'b1;
    tick();
    bus.pc_load = 1'b0;
  endtask
  task automatic pulse_reti();
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
  endtask
  task automatic test_reset();
    bus.irq_req = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.gie_set = 0; bus.gie_clr = 0;
    bus.pc_load = 0; bus.pc_addr = '0; bus.reti = 0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL reset_int got=%0b exp=0", bus.interrupt); end
    tests++; if (bus.interrupt_addr !== 32'h10) begin fails++; $display("FAIL reset_addr got=%h exp=10", bus.interrupt_addr); end
    tests++; if (bus.ret_addr !== 32'h0) begin fails++; $display("FAIL reset_ret got=%h exp=0", bus.ret_addr); end
    tests++; if (bus.in_service !== 1'b0) begin fails++; $display("FAIL reset_svc got=%0b exp=0", bus.in_service); end
    tests++; if (bus.irq_id !== 4'd0) begin fails++; $display("FAIL reset_id got=%0d exp=0", bus.irq_id); end
    tests++; if (bus.irq_ack !== 4'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0000", bus.irq_ack); end
  endtask
  task automatic test_basic_arm();
    bus.mask_we = 1; bus.mask_wdata = 4'b0000; bus.gie_set = 1;
    tick();
    bus.mask_we = 0; bus.gie_set = 0;
    bus.irq_req = 4'b0100;
    tick();
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL arm_latency1 got=%0b exp=0", bus.interrupt); end
    tick();
    tests++; if (bus.interrupt !== 1'b1) begin fails++; $display("FAIL arm_int got=%0b exp=1", bus.interrupt); end
    tests++; if (bus.interrupt_addr !== 32'h18) begin fails++; $display("FAIL arm_addr got=%h exp=18", bus.interrupt_addr); end
    tests++; if (bus.irq_id !== 4'd2) begin fails++; $display("FAIL arm_id got=%0d exp=2", bus.irq_id); end
  endtask
  task automatic test_accept();
    pulse_load(32'h40);
    tests++; if (bus.ret_addr !== 32'h40) begin fails++; $display("FAIL acc_ret got=%h exp=40", bus.ret_addr); end
    tests++; if (bus.irq_ack !== 4'b0100) begin fails++; $display("FAIL acc_ack got=%b exp=0100", bus.irq_ack); end
    tests++; if (bus.in_service !== 1'b1) begin fails++; $display("FAIL acc_svc got=%0b exp=1", bus.in_service); end
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL acc_int got=%0b exp=0", bus.interrupt); end
    tick();
    tests++; if (bus.irq_ack !== 4'b0000) begin fails++; $display("FAIL acc_ack_pulse got=%b exp=0000", bus.irq_ack); end
    pulse_reti();
    tests++; if (bus.in_service !== 1'b0) begin fails++; $display("FAIL acc_reti_svc got=%0b exp=0", bus.in_service); end
    tick(2);
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL held_level_no_rearm got=%0b exp=0", bus.interrupt); end
  endtask
  task automatic test_preempt();
    bus.irq_req = 4'b1100;
    tick(2);
    tests++; if (bus.irq_id !== 4'd3) begin fails++; $display("FAIL pre_id3 got=%0d exp=3", bus.irq_id); end
    bus.irq_req = 4'b1101;
    tick(2);
    tests++; if (bus.irq_id !== 4'd0) begin fails++; $display("FAIL pre_id0 got=%0d exp=0", bus.irq_id); end
    tests++; if (bus.interrupt_addr !== 32'h10) begin fails++; $display("FAIL pre_addr got=%h exp=10", bus.interrupt_addr); end
    tests++; if (bus.interrupt !== 1'b1) begin fails++; $display("FAIL pre_int got=%0b exp=1", bus.interrupt); end
    pulse_load(32'h80);
    tests++; if (bus.irq_ack !== 4'b0001) begin fails++; $display("FAIL pre_ack got=%b exp=0001", bus.irq_ack); end
    tests++; if (bus.ret_addr !== 32'h80) begin fails++; $display("FAIL pre_ret got=%h exp=80", bus.ret_addr); end
    pulse_reti();
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL pre_idle got=%0b exp=0", bus.interrupt); end
    tick();
    tests++; if (bus.interrupt !== 1'b1 || bus.irq_id !== 4'd3) begin fails++; $display("FAIL pre_line3 got int=%0b id=%0d exp int=1 id=3", bus.interrupt, bus.irq_id); end
    tests++; if (bus.interrupt_addr !== 32'h1C) begin fails++; $display("FAIL pre_addr3 got=%h exp=1c", bus.interrupt_addr); end
    pulse_load(32'h90);
    tests++; if (bus.irq_ack !== 4'b1000) begin fails++; $display("FAIL pre_ack3 got=%b exp=1000", bus.irq_ack); end
    pulse_reti();
  endtask
  task automatic test_reti_pending();
    bus.irq_req = 4'b0000;
    tick();
    bus.irq_req = 4'b0100;
    tick(2);
    pulse_load(32'h100);
    bus.irq_req = 4'b0110;
    tick(2);
    tests++; if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b1) begin fails++; $display("FAIL svc_no_nest got int=%0b svc=%0b exp int=0 svc=1", bus.interrupt, bus.in_service); end
    pulse_reti();
    tests++; if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b0) begin fails++; $display("FAIL reti_idle got int=%0b svc=%0b exp 0 0", bus.interrupt, bus.in_service); end
    tick();
    tests++; if (bus.interrupt !== 1'b1) begin fails++; $display("FAIL reti_rearm got=%0b exp=1", bus.interrupt); end
    tests++; if (bus.interrupt_addr !== 32'h14) begin fails++; $display("FAIL reti_addr got=%h exp=14", bus.interrupt_addr); end
    pulse_load(32'h104);
    pulse_reti();
  endtask
  task automatic test_mask_gie();
    bus.mask_we = 1; bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 0;
    bus.irq_req = 4'b0000;
    tick();
    bus.irq_req = 4'b0010;
    tick(3);
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL masked_int got=%0b exp=0", bus.interrupt); end
    bus.mask_we = 1; bus.mask_wdata = 4'b0000;
    tick();
    bus.mask_we = 0;
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL unmask_early got=%0b exp=0", bus.interrupt); end
    tick();
    tests++; if (bus.interrupt !== 1'b1 || bus.irq_id !== 4'd1) begin fails++; $display("FAIL unmask_int got int=%0b id=%0d exp int=1 id=1", bus.interrupt, bus.irq_id); end
    bus.gie_clr = 1;
    tick();
    bus.gie_clr = 0;
    tick(4);
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL gie_off_int got=%0b exp=0", bus.interrupt); end
    bus.gie_set = 1;
    tick();
    bus.gie_set = 0;
    tick();
    tests++; if (bus.interrupt !== 1'b1) begin fails++; $display("FAIL gie_on_int got=%0b exp=1", bus.interrupt); end
    pulse_load(32'h200);
    pulse_reti();
  endtask
  task automatic test_reset_mid();
    bus.irq_req = 4'b0000;
    tick();
    bus.irq_req = 4'b0001;
    tick(2);
    pulse_load(32'h300);
    bus.irq_req = 4'b1011;
    tick(2);
    rst = 1'b1;
    bus.irq_req = 4'b0000;
    #2;
    tests++; if (bus.in_service !== 1'b0 || bus.ret_addr !== 32'h0) begin fails++; $display("FAIL rst_async got svc=%0b ret=%h exp 0 0", bus.in_service, bus.ret_addr); end
    tick();
    rst = 1'b0;
    tick();
    tests++; if (bus.interrupt !== 1'b0 || bus.interrupt_addr !== 32'h10 || bus.irq_id !== 4'd0 || bus.irq_ack !== 4'b0) begin fails++; $display("FAIL rst_outputs got int=%0b addr=%h id=%0d ack=%b exp 0 10 0 0000", bus.interrupt, bus.interrupt_addr, bus.irq_id, bus.irq_ack); end
    bus.mask_we = 1; bus.mask_wdata = 4'b0000; bus.gie_set = 1;
    tick();
    bus.mask_we = 0; bus.gie_set = 0;
    tick(3);
    tests++; if (bus.interrupt !== 1'b0) begin fails++; $display("FAIL rst_pending_cleared got=%0b exp=0", bus.interrupt); end
  endtask
  task automatic test_back_to_back();
    bus.irq_req = 4'b0010;
    tick(2);
    tests++; if (bus.irq_id !== 4'd1 || bus.interrupt !== 1'b1) begin fails++; $display("FAIL b2b_arm got int=%0b id=%0d exp 1 1", bus.interrupt, bus.irq_id); end
    bus.irq_req = 4'b0000;
    tick();
    bus.irq_req = 4'b0010;
    pulse_load(32'h400);
    tests++; if (bus.irq_ack !== 4'b0010) begin fails++; $display("FAIL b2b_ack got=%b exp=0010", bus.irq_ack); end
    tick();
    pulse_reti();
    tick();
    tests++; if (bus.interrupt !== 1'b1 || bus.irq_id !== 4'd1) begin fails++; $display("FAIL b2b_edge_wins got int=%0b id=%0d exp 1 1", bus.interrupt, bus.irq_id); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_arm();
    test_accept();
    test_preempt();
    test_reti_pending();
    test_mask_gie();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
